// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader and its neighbours (memory, CPU).
// State encodings are plain localparams so older code that compares raw
// state values keeps working.
package program_loader_pkg;

    localparam int MEM_WIDTH = 8;
    localparam int MEM_DEPTH = 256;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GET_ADDR = 3'd1;
    localparam logic [2:0] ST_GET_LEN  = 3'd2;
    localparam logic [2:0] ST_GET_DATA = 3'd3;
    localparam logic [2:0] ST_WRITE    = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
    localparam logic [2:0] ST_GET_SUM  = 3'd6;

    // States in the middle of a frame that are waiting for the next byte;
    // these are the states the inter-byte timeout watches.
    function automatic logic isWaitState(input logic [2:0] st);
        return (st == ST_GET_ADDR) || (st == ST_GET_LEN) ||
               (st == ST_GET_DATA) || (st == ST_GET_SUM);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter for the program loader. Counts cycles while
// enabled, restarts on every transfer, and flags the cycle in which the
// gap reaches TIMEOUT_CYCLES-1 without a transfer.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Held at zero outside the waiting states, restarted by each transfer.
    always_comb begin
        count_d = count_q;
        if (!enable || clear || (count_q == CNT_LAST)) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && !clear && (count_q == CNT_LAST);

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream (SYNC, address, length,
// data...) over valid/ready and writes it into the 256x8 program memory,
// holding the CPU while a frame is in flight.
// Optional macro LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [MEM_WIDTH-1:0] mem_address,
    output logic                 mem_ie,
    output logic                 mem_oe,
    inout  wire  [MEM_WIDTH-1:0] bus,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 load_err
);

    logic [2:0] state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [8:0] remCount_q, remCount_d;
    logic       loadErr_q, loadErr_d;
    logic       running_q;
    logic       xfer;
    logic       timeoutExpired;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
`endif

    assign rx_ready    = running_q && ((state_q == ST_IDLE) || isWaitState(state_q));
    assign xfer        = rx_valid && rx_ready;
    assign mem_ie      = (state_q == ST_WRITE);
    assign mem_oe      = 1'b0;
    assign mem_address = addr_q;
    assign bus         = mem_ie ? data_q : 8'bz;
    assign cpu_hold    = isWaitState(state_q) || (state_q == ST_WRITE);
    assign load_done   = (state_q == ST_DONE);
    assign load_err    = loadErr_q;

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (isWaitState(state_q)),
        .clear  (xfer),
        .expired(timeoutExpired)
    );

    // Frame sequencing: next state and datapath updates for each received byte.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        remCount_d = remCount_q;
        loadErr_d  = loadErr_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        if (timeoutExpired) begin
            loadErr_d = 1'b1;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer && (rx_data == SYNC_BYTE)) begin
                        loadErr_d = 1'b0;
                        state_d   = ST_GET_ADDR;
                    end
                end
                ST_GET_ADDR: begin
                    if (xfer) begin
                        addr_d  = rx_data;
                        state_d = ST_GET_LEN;
                    end
                end
                ST_GET_LEN: begin
                    if (xfer) begin
                        remCount_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
`ifdef LOADER_CHECKSUM_EN
                        sum_d      = 8'd0;
`endif
                        state_d    = ST_GET_DATA;
                    end
                end
                ST_GET_DATA: begin
                    if (xfer) begin
                        data_d  = rx_data;
`ifdef LOADER_CHECKSUM_EN
                        sum_d   = sum_q + rx_data;
`endif
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    addr_d     = addr_q + 8'd1;
                    remCount_d = remCount_q - 9'd1;
                    if (remCount_q == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_GET_SUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_GET_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_GET_SUM: begin
                    if (xfer) begin
                        if (rx_data == sum_q) begin
                            state_d = ST_DONE;
                        end else begin
                            loadErr_d = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; running_q keeps rx_ready low while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= 8'd0;
            data_q     <= 8'd0;
            remCount_q <= 9'd0;
            loadErr_q  <= 1'b0;
            running_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            remCount_q <= remCount_d;
            loadErr_q  <= loadErr_d;
            running_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader with a behavioural 256x8 memory
// that samples on the falling clock edge. Works with or without
// LOADER_CHECKSUM_EN; checksum bytes are only sent when it is defined.
module tb_program_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] mem_address;
    logic       mem_ie;
    logic       mem_oe;
    wire  [7:0] bus;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    logic [7:0] tbMem [256];
    int testsRun;
    int testsFailed;
    int writeCount;
    int doneCount;
    int readyViolations;
    int holdViolations;
    int doneBase;
    int writeBase;

    program_loader #(
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_address(mem_address),
        .mem_ie     (mem_ie),
        .mem_oe     (mem_oe),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory plus pulse counters and protocol watchers.
    always @(negedge clk) begin
        if (mem_ie) begin
            tbMem[mem_address] = bus;
            writeCount++;
            if (rx_ready) readyViolations++;
            if (!cpu_hold) holdViolations++;
        end
        if (load_done) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Present one byte and return at the falling edge after it was accepted.
    task automatic applyStimulus(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("rxReadyWait", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    task automatic sendSum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(b);
`else
        b = b;
`endif
    endtask

    task automatic idleCycles(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        testsRun = 0; testsFailed = 0; writeCount = 0; doneCount = 0;
        readyViolations = 0; holdViolations = 0;
        for (int i = 0; i < 256; i++) tbMem[i] = 8'h00;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("rstReady", rx_ready, 0);
        checkOutput("rstMemIe", mem_ie, 0);
        checkOutput("rstMemOe", mem_oe, 0);
        checkOutput("rstAddr", mem_address, 0);
        checkOutput("rstHold", cpu_hold, 0);
        checkOutput("rstDone", load_done, 0);
        checkOutput("rstErr", load_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idleReady", rx_ready, 1);

        // Basic load.
        doneBase = doneCount; writeBase = writeCount;
        applyStimulus(8'hA5);
        checkOutput("basicHoldAfterSync", cpu_hold, 1);
        applyStimulus(8'h10); applyStimulus(8'h03);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
        sendSum(8'h66);
        idleCycles(4);
        checkOutput("basicMem10", tbMem[8'h10], 8'h11);
        checkOutput("basicMem11", tbMem[8'h11], 8'h22);
        checkOutput("basicMem12", tbMem[8'h12], 8'h33);
        checkOutput("basicWrites", writeCount - writeBase, 3);
        checkOutput("basicDone", doneCount - doneBase, 1);
        checkOutput("basicHoldEnd", cpu_hold, 0);
        checkOutput("basicErr", load_err, 0);

        // Address wrap with length 0 (256 bytes).
        doneBase = doneCount; writeBase = writeCount;
        applyStimulus(8'hA5); applyStimulus(8'hFE); applyStimulus(8'h00);
        for (int i = 0; i < 256; i++) applyStimulus(8'(i));
        sendSum(8'h80);
        idleCycles(4);
        checkOutput("wrapMemFE", tbMem[8'hFE], 8'h00);
        checkOutput("wrapMemFF", tbMem[8'hFF], 8'h01);
        checkOutput("wrapMem00", tbMem[8'h00], 8'h02);
        checkOutput("wrapMem7F", tbMem[8'h7F], 8'h81);
        checkOutput("wrapMemFD", tbMem[8'hFD], 8'hFF);
        checkOutput("wrapWrites", writeCount - writeBase, 256);
        checkOutput("wrapDone", doneCount - doneBase, 1);

        // Garbage before the frame and a sync value inside the data.
        doneBase = doneCount;
        applyStimulus(8'h00); applyStimulus(8'hFF);
        checkOutput("garbageNoHold", cpu_hold, 0);
        applyStimulus(8'hA5); applyStimulus(8'h20); applyStimulus(8'h02);
        applyStimulus(8'hA5); applyStimulus(8'h5A);
        sendSum(8'hFF);
        idleCycles(4);
        checkOutput("garbageMem20", tbMem[8'h20], 8'hA5);
        checkOutput("garbageMem21", tbMem[8'h21], 8'h5A);
        checkOutput("garbageDone", doneCount - doneBase, 1);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: write kept, error raised, no done pulse.
        doneBase = doneCount;
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h01);
        applyStimulus(8'h42); applyStimulus(8'h00);
        idleCycles(3);
        checkOutput("sumErrMem00", tbMem[8'h00], 8'h42);
        checkOutput("sumErrFlag", load_err, 1);
        checkOutput("sumErrNoDone", doneCount - doneBase, 0);
        checkOutput("sumErrHold", cpu_hold, 0);
        applyStimulus(8'hA5);
        checkOutput("sumErrCleared", load_err, 0);
        applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h43);
        applyStimulus(8'h43);
        idleCycles(3);
        checkOutput("sumOkDone", doneCount - doneBase, 1);
        checkOutput("sumOkErr", load_err, 0);
`endif

        // Timeout after the address byte (16-cycle limit).
        applyStimulus(8'hA5); applyStimulus(8'h30);
        idleCycles(10);
        checkOutput("toNotYetErr", load_err, 0);
        checkOutput("toNotYetHold", cpu_hold, 1);
        idleCycles(10);
        checkOutput("toErr", load_err, 1);
        checkOutput("toHold", cpu_hold, 0);
        checkOutput("toIdleReady", rx_ready, 1);
        checkOutput("toBusReleased", mem_ie, 0);
        doneBase = doneCount;
        applyStimulus(8'hA5);
        checkOutput("toErrCleared", load_err, 0);
        applyStimulus(8'h40); applyStimulus(8'h01); applyStimulus(8'h77);
        sendSum(8'h77);
        idleCycles(4);
        checkOutput("toRecoverMem40", tbMem[8'h40], 8'h77);
        checkOutput("toRecoverDone", doneCount - doneBase, 1);

        // Reset in the middle of a frame, during a WRITE cycle.
        for (int i = 8'h50; i < 8'h54; i++) tbMem[i] = 8'h00;
        doneBase = doneCount;
        applyStimulus(8'hA5); applyStimulus(8'h50); applyStimulus(8'h04);
        applyStimulus(8'h01); applyStimulus(8'h02);
        checkOutput("midWriteIe", mem_ie, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstIe", mem_ie, 0);
        checkOutput("midRstHold", cpu_hold, 0);
        checkOutput("midRstReady", rx_ready, 0);
        checkOutput("midRstAddr", mem_address, 0);
        checkOutput("midRstErr", load_err, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(3);
        checkOutput("midRstMem50", tbMem[8'h50], 8'h01);
        checkOutput("midRstMem52", tbMem[8'h52], 8'h00);
        checkOutput("midRstNoDone", doneCount - doneBase, 0);

        // Whole-run protocol watchers.
        checkOutput("readyLowInWrite", readyViolations, 0);
        checkOutput("holdHighInWrite", holdViolations, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

endmodule
